// File: rtl/sram_ctrl_pkg.sv
// Shared types and defaults for the SRAM access controller.
// The optional parity feature is enabled by defining SRAM_CTRL_PARITY_EN.
package sram_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_PRE   = 3'd1,
        ST_ACC   = 3'd2,
        ST_SENSE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Request encoding produced by the upstream op/select FSM
    localparam logic RW_READ  = 1'b0;
    localparam logic RW_WRITE = 1'b1;

    localparam int DEF_ADDR_W  = 2;
    localparam int DEF_DATA_W  = 4;
    localparam int DEF_PRE_CYC = 1;
    localparam int DEF_WL_CYC  = 2;

endpackage

// File: rtl/sram_row_decoder.sv
// Combinational address-to-wordline decoder; output is one-hot when enabled, zero otherwise.
module sram_row_decoder #(
    parameter int ADDR_W = 2,
    parameter int DEPTH  = 4
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [DEPTH-1:0]  wl
);

    always_comb begin
        wl = '0;
        if (en) begin
            wl[addr] = 1'b1;
        end
    end

endmodule

// File: rtl/sram_access_ctrl.sv
// Sequences one precharge / wordline / sense access per request over a small behavioural array.
// Define SRAM_CTRL_PARITY_EN to store an even-parity bit per word and report parity_err on reads.
module sram_access_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int PRE_CYC = DEF_PRE_CYC,
    parameter int WL_CYC  = DEF_WL_CYC
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 valid,
    input  logic                 rw,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    output logic                 busy,
    output logic                 precharge,
    output logic [(1<<ADDR_W)-1:0] wl,
    output logic                 we,
    output logic                 sae,
    output logic [DATA_W-1:0]    rdata,
`ifdef SRAM_CTRL_PARITY_EN
    output logic                 parity_err,
`endif
    output logic                 done
);

    localparam int DEPTH   = 1 << ADDR_W;
    localparam int MAX_CYC = (PRE_CYC > WL_CYC) ? PRE_CYC : WL_CYC;
    localparam int CNT_W   = $clog2(MAX_CYC) + 1;
`ifdef SRAM_CTRL_PARITY_EN
    localparam int MEM_W   = DATA_W + 1;
`else
    localparam int MEM_W   = DATA_W;
`endif

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic                rw_q, rw_d;
    logic                armed_q, armed_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [MEM_W-1:0]    mem_q [DEPTH];
    logic                mem_we;
    logic [MEM_W-1:0]    mem_wdata;
    logic                wl_en;
`ifdef SRAM_CTRL_PARITY_EN
    logic                perr_q, perr_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rw_d    = rw_q;
        armed_d = armed_q;
        rdata_d = rdata_q;
        mem_we  = 1'b0;
`ifdef SRAM_CTRL_PARITY_EN
        mem_wdata = {^wdata_q, wdata_q};
        perr_d    = 1'b0;
`else
        mem_wdata = wdata_q;
`endif
        // A level-held request must drop once before the next access is accepted
        if (!valid) begin
            armed_d = 1'b1;
        end
        case (state_q)
            ST_IDLE: begin
                if (valid && armed_q) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    rw_d    = rw;
                    cnt_d   = CNT_W'(PRE_CYC - 1);
                    state_d = ST_PRE;
                end
            end
            ST_PRE: begin
                if (cnt_q == '0) begin
                    cnt_d   = CNT_W'(WL_CYC - 1);
                    state_d = ST_ACC;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACC: begin
                if (cnt_q == '0) begin
                    if (rw_q == RW_WRITE) begin
                        mem_we  = 1'b1;
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_SENSE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_SENSE: begin
                rdata_d = mem_q[addr_q][DATA_W-1:0];
`ifdef SRAM_CTRL_PARITY_EN
                perr_d  = ^mem_q[addr_q];
`endif
                state_d = ST_DONE;
            end
            ST_DONE: begin
                armed_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= RW_READ;
            armed_q <= 1'b1;
            rdata_q <= '0;
`ifdef SRAM_CTRL_PARITY_EN
            perr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rw_q    <= rw_d;
            armed_q <= armed_d;
            rdata_q <= rdata_d;
`ifdef SRAM_CTRL_PARITY_EN
            perr_q  <= perr_d;
`endif
        end
    end

    // Array is not reset; a reset on the commit edge suppresses the write
    always_ff @(posedge clk) begin
        if (mem_we && !rst) begin
            mem_q[addr_q] <= mem_wdata;
        end
    end

`ifdef SRAM_CTRL_PARITY_EN
    task automatic flip_bit(input int word, input int bit_idx);
        mem_q[word][bit_idx] = ~mem_q[word][bit_idx];
    endtask

    assign parity_err = perr_q;
`endif

    assign busy      = (state_q != ST_IDLE);
    assign precharge = (state_q == ST_IDLE) || (state_q == ST_PRE);
    assign wl_en     = (state_q == ST_ACC) || (state_q == ST_SENSE);
    assign we        = (state_q == ST_ACC) && (rw_q == RW_WRITE);
    assign sae       = (state_q == ST_SENSE);
    assign done      = (state_q == ST_DONE);
    assign rdata     = rdata_q;

    sram_row_decoder #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_row_decoder (
        .addr (addr_q),
        .en   (wl_en),
        .wl   (wl)
    );

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Directed bench for sram_access_ctrl: a scoreboard queue holds the expected result of each
// accepted request and a negedge monitor checks it whenever done is presented.
module tb_sram_access_ctrl;
    import sram_ctrl_pkg::*;

    logic       clk;
    logic       rst;
    logic       valid;
    logic       rw;
    logic [1:0] addr;
    logic [3:0] wdata;
    logic       busy;
    logic       precharge;
    logic [3:0] wl;
    logic       we;
    logic       sae;
    logic [3:0] rdata;
    logic       done;
`ifdef SRAM_CTRL_PARITY_EN
    logic       parity_err;
`endif

    typedef struct {
        logic       isRead;
        logic [3:0] data;
    } exp_t;

    exp_t expQ[$];
    int   nVectors;
    int   nMiscompares;

    sram_access_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .valid     (valid),
        .rw        (rw),
        .addr      (addr),
        .wdata     (wdata),
        .busy      (busy),
        .precharge (precharge),
        .wl        (wl),
        .we        (we),
        .sae       (sae),
        .rdata     (rdata),
`ifdef SRAM_CTRL_PARITY_EN
        .parity_err(parity_err),
`endif
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        nVectors++;
        if (act !== exp) begin
            nMiscompares++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drives a request; pushes the expected completion when one is due
    task automatic applyStimulus(input logic rwIn, input logic [1:0] a, input logic [3:0] d,
                                 input logic push, input logic [3:0] expData);
        exp_t e;
        valid = 1'b1;
        rw    = rwIn;
        addr  = a;
        wdata = d;
        if (push) begin
            e.isRead = (rwIn == RW_READ);
            e.data   = expData;
            expQ.push_back(e);
        end
    endtask

    task automatic waitDone();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done) break;
        end
        checkOutput("done_seen", {7'd0, done}, 8'd1);
    endtask

    task automatic runRequest(input logic rwIn, input logic [1:0] a, input logic [3:0] d,
                              input logic [3:0] expData);
        applyStimulus(rwIn, a, d, 1'b1, expData);
        waitDone();
        valid = 1'b0;
        tick();
        tick();
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (expQ.size() == 0) begin
                    nVectors++;
                    nMiscompares++;
                    $display("[TB] FAIL unexpected_done: got done=1, expected no completion at %0t", $time);
                end else begin
                    exp_t e;
                    e = expQ.pop_front();
                    if (e.isRead) checkOutput("sb_rdata", {4'd0, rdata}, {4'd0, e.data});
                end
            end
            if (precharge && (wl != 4'd0)) begin
                nMiscompares++;
                $display("[TB] FAIL inv_pre_wl: got wl=%0h with precharge=1, expected wl=0", wl);
            end
            if (we && sae) begin
                nMiscompares++;
                $display("[TB] FAIL inv_we_sae: got we=1 sae=1, expected not both");
            end
            if (!$onehot0(wl)) begin
                nMiscompares++;
                $display("[TB] FAIL inv_wl_onehot: got wl=%0h, expected one-hot or zero", wl);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        nVectors     = 0;
        nMiscompares = 0;
        rst   = 1'b1;
        valid = 1'b0;
        rw    = RW_READ;
        addr  = 2'd0;
        wdata = 4'd0;
        tick();
        tick();
        rst = 1'b0;

        // Idle after reset
        for (int i = 0; i < 5; i++) begin
            tick();
            checkOutput("idle_precharge", {7'd0, precharge}, 8'd1);
            checkOutput("idle_busy",      {7'd0, busy},      8'd0);
            checkOutput("idle_wl",        {4'd0, wl},        8'd0);
            checkOutput("idle_done",      {7'd0, done},      8'd0);
        end
        checkOutput("idle_rdata", {4'd0, rdata}, 8'd0);

        // Write A to addr 2 with valid held for 10 cycles
        applyStimulus(RW_WRITE, 2'd2, 4'hA, 1'b1, 4'h0);
        tick();
        checkOutput("wr_pre_precharge", {7'd0, precharge}, 8'd1);
        checkOutput("wr_pre_busy",      {7'd0, busy},      8'd1);
        checkOutput("wr_pre_wl",        {4'd0, wl},        8'd0);
        for (int i = 0; i < 2; i++) begin
            tick();
            checkOutput("wr_acc_wl",        {4'd0, wl},        8'h04);
            checkOutput("wr_acc_we",        {7'd0, we},        8'd1);
            checkOutput("wr_acc_precharge", {7'd0, precharge}, 8'd0);
            checkOutput("wr_acc_done",      {7'd0, done},      8'd0);
        end
        tick();
        checkOutput("wr_done",      {7'd0, done}, 8'd1);
        checkOutput("wr_done_busy", {7'd0, busy}, 8'd1);
        for (int i = 0; i < 6; i++) begin
            tick();
            checkOutput("wr_held_done", {7'd0, done}, 8'd0);
            checkOutput("wr_held_busy", {7'd0, busy}, 8'd0);
        end
        valid = 1'b0;
        tick();
        tick();

        // Read addr 2
        applyStimulus(RW_READ, 2'd2, 4'h0, 1'b1, 4'hA);
        tick();
        tick();
        tick();
        tick();
        checkOutput("rd_sense_sae", {7'd0, sae}, 8'd1);
        checkOutput("rd_sense_we",  {7'd0, we},  8'd0);
        checkOutput("rd_sense_wl",  {4'd0, wl},  8'h04);
        tick();
        checkOutput("rd_done",       {7'd0, done},  8'd1);
        checkOutput("rd_done_rdata", {4'd0, rdata}, 8'h0A);
        valid = 1'b0;
        tick();
        tick();
        tick();
        checkOutput("rd_hold_rdata", {4'd0, rdata}, 8'h0A);

        // Inputs changed mid-write are ignored
        runRequest(RW_WRITE, 2'd1, 4'h6, 4'h0);
        applyStimulus(RW_WRITE, 2'd2, 4'h9, 1'b1, 4'h0);
        tick();
        tick();
        addr  = 2'd1;
        wdata = 4'h5;
        rw    = RW_READ;
        waitDone();
        valid = 1'b0;
        tick();
        tick();
        runRequest(RW_READ, 2'd2, 4'h0, 4'h9);
        runRequest(RW_READ, 2'd1, 4'h0, 4'h6);

        // Reset during a write leaves the old word
        runRequest(RW_WRITE, 2'd0, 4'h3, 4'h0);
        applyStimulus(RW_WRITE, 2'd0, 4'hF, 1'b0, 4'h0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        checkOutput("rst_precharge", {7'd0, precharge}, 8'd1);
        checkOutput("rst_busy",      {7'd0, busy},      8'd0);
        checkOutput("rst_wl",        {4'd0, wl},        8'd0);
        checkOutput("rst_we",        {7'd0, we},        8'd0);
        checkOutput("rst_sae",       {7'd0, sae},       8'd0);
        checkOutput("rst_rdata",     {4'd0, rdata},     8'd0);
        checkOutput("rst_done",      {7'd0, done},      8'd0);
        rst   = 1'b0;
        valid = 1'b0;
        tick();
        tick();
        runRequest(RW_READ, 2'd0, 4'h0, 4'h3);

`ifdef SRAM_CTRL_PARITY_EN
        runRequest(RW_WRITE, 2'd3, 4'h7, 4'h0);
        dut.flip_bit(3, 0);
        applyStimulus(RW_READ, 2'd3, 4'h0, 1'b1, 4'h6);
        waitDone();
        checkOutput("par_err_flipped", {7'd0, parity_err}, 8'd1);
        valid = 1'b0;
        tick();
        tick();
        applyStimulus(RW_READ, 2'd2, 4'h0, 1'b1, 4'h9);
        waitDone();
        checkOutput("par_err_clean", {7'd0, parity_err}, 8'd0);
        valid = 1'b0;
        tick();
        tick();
`endif

        checkOutput("sb_drained", expQ.size() > 255 ? 8'hFF : 8'(expQ.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nMiscompares);
        $finish;
    end

endmodule
